// File: rtl/vga_rom_pixel_fetch_pkg.sv
// Shared definitions for the VGA photo path.
// Provides the active raster size, the scan coordinate width, the fetch
// state encoding and a small window-span helper used by the pixel fetcher.
// No ports: this is a package imported by the fetch datapath files.
package vga_rom_pixel_fetch_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int COORD_W  = 16;

  typedef enum logic [1:0] {
    WAIT_TOP = 2'd0,
    IN_IMAGE = 2'd1,
    DONE     = 2'd2
  } fetch_state_t;

  // True when lo <= v < hi, all as unsigned coordinate values.
  function automatic logic in_span(input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_rom_pixel_fetch_delay_line.sv
// Reset-clearable shift register used to keep side-band flags aligned with
// data travelling through a fixed-latency path.
// Ports:
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset, clears every stage
//   din    in   WIDTH  value entering the line
//   dout   out  WIDTH  value from DEPTH clocks earlier
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Plain shift chain; stage 0 takes the new value, each later stage takes
  // its predecessor, so dout lags din by exactly DEPTH clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_rom_pixel_fetch.sv
// Picture source for the 800x600 VGA photo path. Turns the driver's scan
// coordinate into image ROM addresses and hands back a latency-aligned pixel
// byte: ROM data inside the image window, BG_COLOR everywhere else.
// Total latency from coordinate to data_out/data_vld is ROM_LAT+2 clocks.
// Ports:
//   clk          in   1       pixel clock
//   rst_n        in   1       asynchronous active-low reset
//   frame_start  in   1       one-cycle pulse at vertical sync start
//   de           in   1       display enable; vga_x/vga_y valid when 1
//   vga_x        in   16      current column
//   vga_y        in   16      current line
//   rom_addr     out  ROM_AW  image ROM address (registered)
//   rom_q        in   8       image ROM data, ROM_LAT clocks after rom_addr
//   data_out     out  8       pixel byte to the driver
//   data_vld     out  1       data_out belongs to a de=1 input cycle
//   img_done     out  1       last image pixel already fetched this frame
module vga_rom_pixel_fetch
  import vga_rom_pixel_fetch_pkg::*;
#(
  parameter int          IMG_W    = 200,
  parameter int          IMG_H    = 150,
  parameter int          IMG_X0   = 300,
  parameter int          IMG_Y0   = 225,
  parameter int          ROM_AW   = 16,
  parameter int          ROM_LAT  = 1,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               de,
  input  logic [COORD_W-1:0] vga_x,
  input  logic [COORD_W-1:0] vga_y,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [7:0]         rom_q,
  output logic [7:0]         data_out,
  output logic               data_vld,
  output logic               img_done
);

  localparam int PIX_COUNT = IMG_W * IMG_H;

  if (PIX_COUNT > (1 << ROM_AW)) begin : g_bad_rom_aw
    $error("vga_rom_pixel_fetch: image does not fit in ROM_AW address bits");
  end
  if ((ROM_LAT < 1) || (ROM_LAT > 2)) begin : g_bad_rom_lat
    $error("vga_rom_pixel_fetch: ROM_LAT must be 1 or 2");
  end
  if ((IMG_X0 + IMG_W > H_ACTIVE) || (IMG_Y0 + IMG_H > V_ACTIVE)) begin : g_bad_window
    $error("vga_rom_pixel_fetch: image window exceeds the active raster");
  end

  localparam logic [ROM_AW-1:0]  ADDR_LAST = ROM_AW'(PIX_COUNT - 1);
  localparam logic [COORD_W-1:0] X_LO      = COORD_W'(IMG_X0);
  localparam logic [COORD_W-1:0] X_HI      = COORD_W'(IMG_X0 + IMG_W);
  localparam logic [COORD_W-1:0] Y_LO      = COORD_W'(IMG_Y0);
  localparam logic [COORD_W-1:0] Y_HI      = COORD_W'(IMG_Y0 + IMG_H);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ROM_AW-1:0] addr_cnt;
  logic              win;
  logic              fetch;
  logic              at_last;
  logic [1:0]        flags_in;
  logic [1:0]        flags_d;
  logic              win_d;
  logic              de_d;

  // A pixel is in the image window only while the driver says the
  // coordinate is valid. A frame_start in the same cycle cancels the fetch,
  // and once the whole image has been read further window pixels are not
  // fetched again (the address simply stays on the last pixel).
  always_comb begin
    win     = de && in_span(vga_x, X_LO, X_HI) && in_span(vga_y, Y_LO, Y_HI);
    fetch   = win && !frame_start && (state != DONE);
    at_last = (addr_cnt == ADDR_LAST);
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_TOP;
    end else begin
      state <= next_state;
    end
  end

  // frame_start restarts the image from any state. The first fetched pixel
  // leaves WAIT_TOP; issuing the last address moves to DONE, which is only
  // left by the next frame_start. A one-pixel image goes straight to DONE.
  always_comb begin
    next_state = state;
    if (frame_start) begin
      next_state = WAIT_TOP;
    end else begin
      case (state)
        WAIT_TOP: begin
          if (fetch) begin
            next_state = at_last ? DONE : IN_IMAGE;
          end
        end
        IN_IMAGE: begin
          if (fetch && at_last) begin
            next_state = DONE;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = WAIT_TOP;
        end
      endcase
    end
  end

  assign img_done = (state == DONE);

  // Address counter and registered ROM address. Raster order visits window
  // pixels in image order, so a plain running counter walks the ROM row by
  // row without any multiply. The counter parks on the last pixel so stray
  // window cycles after the image keep reading a valid address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
      rom_addr <= '0;
    end else if (frame_start) begin
      addr_cnt <= '0;
    end else if (fetch) begin
      rom_addr <= addr_cnt;
      if (!at_last) begin
        addr_cnt <= addr_cnt + ROM_AW'(1);
      end
    end
  end

  // The window and enable flags ride alongside the address through the
  // register stage plus the ROM latency, so they meet the matching rom_q.
  // A frame_start cycle is forced to background even if it was in window.
  assign flags_in = {win && !frame_start, de};

  vga_delay_line #(
    .DEPTH (ROM_LAT + 1),
    .WIDTH (2)
  ) u_flag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (flags_in),
    .dout  (flags_d)
  );

  assign win_d = flags_d[1];
  assign de_d  = flags_d[0];

  // Output register: ROM byte for window pixels, background otherwise.
  // Blanking cycles travel through as background with data_vld low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      data_vld <= 1'b0;
    end else begin
      data_out <= win_d ? rom_q : BG_COLOR;
      data_vld <= de_d;
    end
  end

endmodule
